// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush sequencer: load-use hazard, taken-branch flush and MDU occupancy timer.
// Optional stall-cycle performance counter is built only when PIPE_PERF_CNT_EN is defined.
module pipe_stall_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             MemRead_ex,
    input  logic [4:0]       RegWriteAddr_ex,
    input  logic [4:0]       RsAddr_id,
    input  logic [4:0]       RtAddr_id,
    input  logic             Branch_taken_ex,
    input  logic             MdStart_id,
    input  logic             MdUseHiLo_id,
    output logic             PC_IFWrite,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             Md_go,
    output logic             Md_busy,
    output logic [CNT_W-1:0] Stall_cnt
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int               TMR_W  = 8;
    localparam logic [TMR_W-1:0] LAT_M1 = TMR_W'(MD_LATENCY - 1);

    logic [0:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic busy;
    logic md_last;
    logic load_use;
    logic hilo_wait;
    logic struct_wait;
    logic stall;
    logic md_go;

    // Gating with rst_n keeps the pipeline free-running while reset is held.
    always_comb begin
        busy        = (state_q == ST_BUSY);
        md_last     = busy && (timer_q == '0);
        load_use    = MemRead_ex && (RegWriteAddr_ex != 5'd0) &&
                      ((RegWriteAddr_ex == RsAddr_id) || (RegWriteAddr_ex == RtAddr_id));
        hilo_wait   = MdUseHiLo_id && busy && !md_last;
        struct_wait = MdStart_id && busy && !md_last;
        stall       = rst_n && (load_use || hilo_wait || struct_wait) && !Branch_taken_ex;
        md_go       = rst_n && MdStart_id && !stall && !Branch_taken_ex;

        PC_IFWrite   = !stall;
        ID_EX_Bubble = stall || (rst_n && Branch_taken_ex);
        IF_ID_Flush  = rst_n && Branch_taken_ex;
        Md_go        = md_go;
        Md_busy      = busy;
    end

    // An issue on the md_last cycle reloads the timer so busy never drops between ops.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        if (md_go) begin
            state_d = ST_BUSY;
            timer_d = LAT_M1;
        end else if (busy) begin
            if (md_last) begin
                state_d = ST_IDLE;
            end else begin
                timer_d = timer_q - TMR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of stall cycles; branch flushes never assert stall.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign Stall_cnt = stall_cnt_q;
`else
    assign Stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: per-cycle vector table through a scoreboard queue,
// plus hand-written reset-mid-busy and stall-counter sequences.
module tb_pipe_stall_ctrl;

    typedef struct {
        logic       mr;
        logic [4:0] wa;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       ms;
        logic       mh;
        logic       pc;
        logic       bub;
        logic       fl;
        logic       go;
        logic       busy;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        mem_read;
    logic [4:0]  wr_addr;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        br_taken;
    logic        md_start;
    logic        md_hilo;
    logic        pc_ifwrite;
    logic        bubble;
    logic        flush;
    logic        md_go;
    logic        md_busy;
    logic [15:0] stall_cnt;
    logic        s_pc, s_bub, s_fl, s_go, s_busy;
    logic [1:0]  s_cnt;

    int checks   = 0;
    int failures = 0;
    int model_cnt = 0;

    vec_t vecs[24];
    vec_t exp_q[$];

    pipe_stall_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead_ex(mem_read), .RegWriteAddr_ex(wr_addr),
        .RsAddr_id(rs_addr), .RtAddr_id(rt_addr), .Branch_taken_ex(br_taken),
        .MdStart_id(md_start), .MdUseHiLo_id(md_hilo), .PC_IFWrite(pc_ifwrite),
        .ID_EX_Bubble(bubble), .IF_ID_Flush(flush), .Md_go(md_go), .Md_busy(md_busy),
        .Stall_cnt(stall_cnt)
    );

    pipe_stall_ctrl #(.MD_LATENCY(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .MemRead_ex(mem_read), .RegWriteAddr_ex(wr_addr),
        .RsAddr_id(rs_addr), .RtAddr_id(rt_addr), .Branch_taken_ex(br_taken),
        .MdStart_id(md_start), .MdUseHiLo_id(md_hilo), .PC_IFWrite(s_pc),
        .ID_EX_Bubble(s_bub), .IF_ID_Flush(s_fl), .Md_go(s_go), .Md_busy(s_busy),
        .Stall_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t mk(input logic mr, input logic [4:0] wa, input logic [4:0] rs,
                                input logic [4:0] rt, input logic br, input logic ms,
                                input logic mh, input logic pc, input logic bub,
                                input logic fl, input logic go, input logic busy);
        vec_t v;
        v.mr = mr; v.wa = wa; v.rs = rs; v.rt = rt; v.br = br; v.ms = ms; v.mh = mh;
        v.pc = pc; v.bub = bub; v.fl = fl; v.go = go; v.busy = busy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic mr, input logic [4:0] wa, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic ms, input logic mh);
        mem_read = mr; wr_addr = wa; rs_addr = rs; rt_addr = rt;
        br_taken = br; md_start = ms; md_hilo = mh;
    endtask

    task automatic check_output(input int row);
        vec_t e;
        string tag;
        if (exp_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = exp_q.pop_front();
        tag = $sformatf("row%0d", row);
        check({tag, "_pc_ifwrite"}, {31'd0, pc_ifwrite}, {31'd0, e.pc});
        check({tag, "_bubble"},     {31'd0, bubble},     {31'd0, e.bub});
        check({tag, "_flush"},      {31'd0, flush},      {31'd0, e.fl});
        check({tag, "_md_go"},      {31'd0, md_go},      {31'd0, e.go});
        check({tag, "_md_busy"},    {31'd0, md_busy},    {31'd0, e.busy});
        if (!e.pc) model_cnt++;
    endtask

    task automatic apply_stimulus(input int row);
        @(negedge clk);
        drive(vecs[row].mr, vecs[row].wa, vecs[row].rs, vecs[row].rt,
              vecs[row].br, vecs[row].ms, vecs[row].mh);
        exp_q.push_back(vecs[row]);
        #2;
        check_output(row);
    endtask

    task automatic check_counters(input string name);
        int exp_main;
        int exp_sat;
`ifdef PIPE_PERF_CNT_EN
        exp_main = (model_cnt > 65535) ? 65535 : model_cnt;
        exp_sat  = (model_cnt > 3) ? 3 : model_cnt;
`else
        exp_main = 0;
        exp_sat  = 0;
`endif
        check({name, "_stall_cnt"},     {16'd0, stall_cnt}, exp_main);
        check({name, "_stall_cnt_sat"}, {30'd0, s_cnt},     exp_sat);
    endtask

    initial begin
        //               mr wa     rs     rt     br ms mh   pc bub fl go busy
        vecs[0]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[1]  = mk(1, 5'd5, 5'd5, 5'd0, 0, 0, 0,  0, 1, 0, 0, 0);
        vecs[2]  = mk(0, 5'd5, 5'd5, 5'd0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[3]  = mk(1, 5'd0, 5'd0, 5'd0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[4]  = mk(1, 5'd7, 5'd1, 5'd7, 0, 0, 0,  0, 1, 0, 0, 0);
        vecs[5]  = mk(1, 5'd7, 5'd1, 5'd2, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[6]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  1, 0, 0, 1, 0);
        vecs[7]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1,  0, 1, 0, 0, 1);
        vecs[8]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1,  0, 1, 0, 0, 1);
        vecs[9]  = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1,  0, 1, 0, 0, 1);
        vecs[10] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 1,  1, 0, 0, 0, 1);
        vecs[11] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[12] = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  1, 0, 0, 1, 0);
        vecs[13] = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  0, 1, 0, 0, 1);
        vecs[14] = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  0, 1, 0, 0, 1);
        vecs[15] = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  0, 1, 0, 0, 1);
        vecs[16] = mk(0, 5'd0, 5'd0, 5'd0, 0, 1, 0,  1, 0, 0, 1, 1);
        vecs[17] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  1, 0, 0, 0, 1);
        vecs[18] = mk(1, 5'd5, 5'd5, 5'd0, 1, 1, 1,  1, 1, 1, 0, 1);
        vecs[19] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  1, 0, 0, 0, 1);
        vecs[20] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  1, 0, 0, 0, 1);
        vecs[21] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  1, 0, 0, 0, 0);
        vecs[22] = mk(0, 5'd0, 5'd0, 5'd0, 1, 1, 0,  1, 1, 1, 0, 0);
        vecs[23] = mk(0, 5'd0, 5'd0, 5'd0, 0, 0, 0,  1, 0, 0, 0, 0);

        rst_n = 1'b0;
        drive(1, 5'd5, 5'd5, 5'd0, 1, 1, 1);
        #3;
        check("reset_pc_ifwrite", {31'd0, pc_ifwrite}, 32'd1);
        check("reset_bubble",     {31'd0, bubble},     32'd0);
        check("reset_flush",      {31'd0, flush},      32'd0);
        check("reset_md_go",      {31'd0, md_go},      32'd0);
        check("reset_md_busy",    {31'd0, md_busy},    32'd0);
        model_cnt = 0;
        check_counters("reset");
        @(negedge clk);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            apply_stimulus(i);
        end
        @(negedge clk);
        check_counters("table");

        // Async reset in the middle of an MDU operation.
        drive(0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
        #2;
        check("mid_issue_md_go", {31'd0, md_go}, 32'd1);
        @(negedge clk);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        #2;
        check("mid_busy_before_reset", {31'd0, md_busy}, 32'd1);
        #1;
        drive(1, 5'd5, 5'd5, 5'd0, 0, 0, 1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_md_busy",    {31'd0, md_busy},    32'd0);
        check("mid_reset_pc_ifwrite", {31'd0, pc_ifwrite}, 32'd1);
        check("mid_reset_bubble",     {31'd0, bubble},     32'd0);
        model_cnt = 0;
        check_counters("mid_reset");
        @(negedge clk);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        rst_n = 1'b1;

        // Three stall cycles, then a fourth to push the narrow counter past saturation.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, 5'd3, 5'd3, 5'd9, 0, 0, 0);
            #2;
            check($sformatf("perf_stall%0d_pc", i), {31'd0, pc_ifwrite}, 32'd0);
            model_cnt++;
        end
        @(negedge clk);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        #2;
        check_counters("perf3");
        @(negedge clk);
        drive(1, 5'd3, 5'd9, 5'd3, 0, 0, 0);
        model_cnt++;
        @(negedge clk);
        drive(0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
        #2;
        check_counters("perf4");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
